// File: rtl/game_pkg.sv
// Shared game types and screen constants.
// Used by the pipe scroller and its gap-height helper.
package game_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int COORD_W  = 11;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FRAME,
    UPDATE,
    DONE
  } scroll_state_t;

endpackage

// File: rtl/gap_height_gen.sv
// Gap height: GAP_MIN plus random LSBs,
// clamped so the gap never drops off screen.
module gap_height_gen
  import game_pkg::*;
#(
  parameter int GAP_MIN   = 200,
  parameter int GAP_MAX   = 470,
  parameter int RAND_BITS = 8
) (
  input  logic [RAND_BITS-1:0] rand_i,
  output coord_t               gap_o
);

  logic [11:0] sum;

  // 12-bit sum so the overflow case is visible before clamping
  assign sum = 12'(GAP_MIN)
             + {{(12-RAND_BITS){1'b0}}, rand_i};

  // saturate to the lowest allowed gap position
  assign gap_o = (sum > 12'(GAP_MAX))
               ? coord_t'(GAP_MAX)
               : sum[10:0];

endmodule

// File: rtl/pipe_scroller.sv
// Pipe position/gap owner: steps all pipes once
// per tick, deferring updates while a frame is busy.
module pipe_scroller
  import game_pkg::*;
#(
  parameter int NUM_PIPES = 2,
  parameter int SCREEN_W  = 640,
  parameter int SPACING   = 320,
  parameter int STEP      = 1,
  parameter int GAP_MIN   = 200,
  parameter int GAP_MAX   = 470,
  parameter int RAND_BITS = 8,
  parameter int BIRD_X    = 100
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   tick,
  input  logic                   enable,
  input  logic                   restart,
  input  logic [9:0]             random,
  input  logic                   frame_busy,
  output coord_t [NUM_PIPES-1:0] pipe_x,
  output coord_t [NUM_PIPES-1:0] pipe_y,
  output logic                   passed,
  output logic                   update_done,
  output logic                   overrun
);

  localparam int IDX_W =
    (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(NUM_PIPES - 1);
  localparam coord_t STEP_C    = coord_t'(STEP);
  localparam coord_t BIRD_C    = coord_t'(BIRD_X);
  localparam coord_t RESPAWN_C = coord_t'(SCREEN_W - 1);

  scroll_state_t state_q, state_d;
  logic          pending_q, pending_d;
  logic          overrun_q, overrun_d;
  logic          pass_q, pass_d;
  logic          passed_q, passed_d;
  logic          done_q, done_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  coord_t [NUM_PIPES-1:0] pipe_x_q, pipe_x_d;
  coord_t [NUM_PIPES-1:0] pipe_y_q, pipe_y_d;

  coord_t gap;
  coord_t cur_x;
  coord_t nxt_x;
  logic   hit;

  gap_height_gen #(
    .GAP_MIN  (GAP_MIN),
    .GAP_MAX  (GAP_MAX),
    .RAND_BITS(RAND_BITS)
  ) u_gap (
    .rand_i(random[RAND_BITS-1:0]),
    .gap_o (gap)
  );

  if (RAND_BITS < 10) begin : g_rand_hi
    logic unused_rand;
    assign unused_rand = ^random[9:RAND_BITS];
  end

  // next-state: tick capture, FSM, per-pipe step, restart override
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    pass_d    = pass_q;
    passed_d  = 1'b0;
    done_d    = 1'b0;
    idx_d     = idx_q;
    pipe_x_d  = pipe_x_q;
    pipe_y_d  = pipe_y_q;
    cur_x     = pipe_x_q[idx_q];
    nxt_x     = cur_x - STEP_C;
    hit       = 1'b0;

    if (tick) begin
      if (pending_q || state_q != IDLE) begin
        overrun_d = 1'b1;
      end else begin
        pending_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (pending_q) begin
          if (enable) begin
            state_d = WAIT_FRAME;
          end else begin
            pending_d = 1'b0;
          end
        end
      end
      WAIT_FRAME: begin
        if (!frame_busy) begin
          state_d   = UPDATE;
          idx_d     = '0;
          pending_d = 1'b0;
          pass_d    = 1'b0;
        end
      end
      UPDATE: begin
        if (cur_x < STEP_C) begin
          pipe_x_d[idx_q] = RESPAWN_C;
          pipe_y_d[idx_q] = gap;
        end else begin
          pipe_x_d[idx_q] = nxt_x;
          hit = (cur_x >= BIRD_C) && (nxt_x < BIRD_C);
        end
        if (idx_q == LAST_IDX) begin
          state_d  = DONE;
          done_d   = 1'b1;
          passed_d = pass_q | hit;
          pass_d   = 1'b0;
        end else begin
          idx_d  = idx_q + 1'b1;
          pass_d = pass_q | hit;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (restart) begin
      state_d   = IDLE;
      pending_d = 1'b0;
      overrun_d = 1'b0;
      pass_d    = 1'b0;
      passed_d  = 1'b0;
      done_d    = 1'b0;
      idx_d     = '0;
      for (int i = 0; i < NUM_PIPES; i++) begin
        pipe_x_d[i] = coord_t'((i + 1) * SPACING - 1);
        pipe_y_d[i] = gap;
      end
    end
  end

  // state and pipe registers; reset restores the initial layout
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      pass_q    <= 1'b0;
      passed_q  <= 1'b0;
      done_q    <= 1'b0;
      idx_q     <= '0;
      for (int i = 0; i < NUM_PIPES; i++) begin
        pipe_x_q[i] <= coord_t'((i + 1) * SPACING - 1);
        pipe_y_q[i] <= coord_t'(GAP_MIN);
      end
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      pass_q    <= pass_d;
      passed_q  <= passed_d;
      done_q    <= done_d;
      idx_q     <= idx_d;
      pipe_x_q  <= pipe_x_d;
      pipe_y_q  <= pipe_y_d;
    end
  end

  assign pipe_x      = pipe_x_q;
  assign pipe_y      = pipe_y_q;
  assign passed      = passed_q;
  assign update_done = done_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_pipe_scroller.sv
// Scoreboard bench for pipe_scroller; a second
// instance with GAP_MIN=400 exercises gap saturation.
module tb_pipe_scroller;

  typedef struct packed {
    logic [10:0] x0;
    logic [10:0] x1;
    logic [10:0] y0;
    logic [10:0] y1;
    logic [10:0] s0;
    logic [10:0] s1;
    logic        pas;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n, tick, enable, restart, frame_busy;
  logic [9:0] random;
  logic [1:0][10:0] px, py, pxs, pys;
  logic passed, update_done, overrun;
  logic pas_s, ud_s, ov_s;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  int mx[2];
  int my[2];
  int ms[2];

  pipe_scroller dut (
    .clk(clk), .reset_n(reset_n), .tick(tick),
    .enable(enable), .restart(restart),
    .random(random), .frame_busy(frame_busy),
    .pipe_x(px), .pipe_y(py), .passed(passed),
    .update_done(update_done), .overrun(overrun)
  );

  pipe_scroller #(.GAP_MIN(400)) dut_sat (
    .clk(clk), .reset_n(reset_n), .tick(tick),
    .enable(enable), .restart(restart),
    .random(random), .frame_busy(frame_busy),
    .pipe_x(pxs), .pipe_y(pys), .passed(pas_s),
    .update_done(ud_s), .overrun(ov_s)
  );

  always #10 clk = ~clk;

  function automatic int gap(int gmin, logic [9:0] r);
    int s;
    s = gmin + int'(r[7:0]);
    return (s > 470) ? 470 : s;
  endfunction

  task automatic model_step(input logic [9:0] r);
    exp_t e;
    logic p;
    int nx;
    p = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (mx[i] < 1) begin
        mx[i] = 639;
        my[i] = gap(200, r);
        ms[i] = gap(400, r);
      end else begin
        nx = mx[i] - 1;
        if (mx[i] >= 100 && nx < 100) p = 1'b1;
        mx[i] = nx;
      end
    end
    e = {11'(mx[0]), 11'(mx[1]), 11'(my[0]),
         11'(my[1]), 11'(ms[0]), 11'(ms[1]), p};
    sb.push_back(e);
  endtask

  task automatic pop_check(input string nm);
    exp_t e, got;
    e = sb.pop_front();
    got = {px[0], px[1], py[0], py[1],
           pys[0], pys[1], passed};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", nm, got, e);
    end
  endtask

  task automatic issue_tick(output int lat,
                            output logic pa);
    int n;
    bit seen;
    model_step(random);
    @(negedge clk);
    tick = 1'b1;
    n = 0;
    seen = 0;
    while (!seen && n < 30) begin
      @(negedge clk);
      tick = 1'b0;
      n++;
      if (update_done) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL tick_timeout got=none required=update_done");
      void'(sb.pop_front());
      lat = -1;
      pa = 1'bx;
    end else begin
      pa = passed;
      lat = n - 1;
      pop_check("scoreboard");
    end
  endtask

  task automatic run_ticks(input int cnt);
    int lat;
    logic pa;
    for (int i = 0; i < cnt; i++) begin
      random = 10'($urandom_range(0, 1023));
      issue_tick(lat, pa);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (px !== {11'd639, 11'd319} ||
        py !== {11'd200, 11'd200} ||
        pys !== {11'd400, 11'd400}) begin
      errors++;
      $display("FAIL reset_pos got=%h %h %h required=27f/13f c8/c8 190/190",
               px, py, pys);
    end
    checks++;
    if ({passed, update_done, overrun} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got=%b required=000",
               {passed, update_done, overrun});
    end
  endtask

  task automatic test_single_tick();
    int lat;
    logic pa;
    random = 10'h000;
    issue_tick(lat, pa);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL latency got=%0d required=4", lat);
    end
    checks++;
    if (px[0] !== 11'd318 || px[1] !== 11'd638) begin
      errors++;
      $display("FAIL first_step got=%0d/%0d required=318/638",
               px[0], px[1]);
    end
    checks++;
    if (pa !== 1'b0) begin
      errors++;
      $display("FAIL first_pass got=%b required=0", pa);
    end
    @(negedge clk);
    checks++;
    if (update_done !== 1'b0) begin
      errors++;
      $display("FAIL done_width got=%b required=0", update_done);
    end
  endtask

  task automatic test_pass();
    int lat;
    logic pa;
    run_ticks(218);
    checks++;
    if (px[0] !== 11'd100) begin
      errors++;
      $display("FAIL pre_pass got=%0d required=100", px[0]);
    end
    issue_tick(lat, pa);
    checks++;
    if (pa !== 1'b1) begin
      errors++;
      $display("FAIL pass_100_99 got=%b required=1", pa);
    end
    @(negedge clk);
    checks++;
    if (passed !== 1'b0) begin
      errors++;
      $display("FAIL pass_width got=%b required=0", passed);
    end
    issue_tick(lat, pa);
    checks++;
    if (pa !== 1'b0 || px[0] !== 11'd98) begin
      errors++;
      $display("FAIL pass_99_98 got=%b x=%0d required=0 x=98",
               pa, px[0]);
    end
  endtask

  task automatic test_respawn();
    int lat;
    logic pa;
    run_ticks(98);
    checks++;
    if (px[0] !== 11'd0) begin
      errors++;
      $display("FAIL pre_respawn got=%0d required=0", px[0]);
    end
    random = 10'h0A5;
    issue_tick(lat, pa);
    checks++;
    if (px[0] !== 11'd639 || py[0] !== 11'd365 ||
        px[1] !== 11'd319) begin
      errors++;
      $display("FAIL respawn got=x%0d y%0d x1=%0d required=639 365 319",
               px[0], py[0], px[1]);
    end
    checks++;
    if (pys[0] !== 11'd470) begin
      errors++;
      $display("FAIL saturate got=%0d required=470", pys[0]);
    end
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL no_overrun got=%b required=0", overrun);
    end
  endtask

  task automatic test_frame_busy();
    logic [1:0][10:0] sx, sy;
    bit bad, seen;
    int n;
    random = 10'h012;
    frame_busy = 1'b1;
    model_step(random);
    sx = px;
    sy = py;
    bad = 0;
    @(negedge clk);
    tick = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      tick = (i == 10);
      if (px !== sx || py !== sy || update_done) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL busy_hold got=changed required=stable");
    end
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun got=%b required=1", overrun);
    end
    frame_busy = 1'b0;
    n = 0;
    seen = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (update_done) seen = 1;
    end
    checks++;
    if (!seen || n != 3) begin
      errors++;
      $display("FAIL busy_latency got=%0d required=3", n);
    end
    if (seen) pop_check("busy_step");
    else void'(sb.pop_front());
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (update_done) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL extra_update got=update required=none");
    end
  endtask

  task automatic test_restart();
    bit bad;
    random = 10'h3FF;
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    mx = '{319, 639};
    my = '{455, 455};
    ms = '{470, 470};
    checks++;
    if (px !== {11'd639, 11'd319} ||
        py !== {11'd455, 11'd455} ||
        pys !== {11'd470, 11'd470}) begin
      errors++;
      $display("FAIL restart_pos got=%h %h %h required=27f/13f 1c7/1c7 1d6/1d6",
               px, py, pys);
    end
    checks++;
    if ({passed, update_done, overrun} !== 3'b000) begin
      errors++;
      $display("FAIL restart_flags got=%b required=000",
               {passed, update_done, overrun});
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (update_done) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL restart_done got=update required=none");
    end
  endtask

  task automatic test_disabled();
    bit bad;
    int lat;
    logic pa;
    enable = 1'b0;
    bad = 0;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (update_done || px !== {11'd639, 11'd319})
          bad = 1;
      end
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL paused got=moved required=still");
    end
    enable = 1'b1;
    random = 10'h055;
    issue_tick(lat, pa);
    checks++;
    if (px[0] !== 11'd318 || px[1] !== 11'd638 ||
        overrun !== 1'b0) begin
      errors++;
      $display("FAIL resume got=%0d/%0d ov=%b required=318/638 ov=0",
               px[0], px[1], overrun);
    end
  endtask

  task automatic test_reset_mid();
    bit bad;
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if (px !== {11'd639, 11'd319} ||
        py !== {11'd200, 11'd200} ||
        update_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got=%h %h %b required=27f/13f c8/c8 0",
               px, py, update_done);
    end
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (update_done || px !== {11'd639, 11'd319})
        bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL reset_resume got=update required=none");
    end
  endtask

  initial begin
    reset_n = 1'b0;
    tick = 1'b0;
    enable = 1'b1;
    restart = 1'b0;
    frame_busy = 1'b0;
    random = 10'h000;
    mx = '{319, 639};
    my = '{200, 200};
    ms = '{400, 400};
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_single_tick();
    test_pass();
    test_respawn();
    test_frame_busy();
    test_restart();
    test_disabled();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
